spi_counter_rx: RTL and testbench
=================================

# spi_counter_rx

SPI mode-0 responder that receives 16-bit counter frames from the master and presents the 14-bit counter value to the display path. It also echoes the last accepted frame back on MISO, so the master can check the link. The block sits on the slave side between the SPI pins (or the on-chip SPI nets in single-board builds) and the FND driver. All SPI inputs are treated as asynchronous and are oversampled in the `clk` domain.

## Interface
- `FRAME_BITS`, 16: bits per frame; MSB first.
- `DATA_W`, 14: payload width; frame = {header[1:0], data[DATA_W-1:0]}.
- `HEADER`, 2'b10: required header value for a valid frame.
- `clk`  in  1  system clock, 100 MHz. Already decided.
- `reset`  in  1  reset, asynchronous, active-high. Already decided.
- `sclk`  in  1  SPI clock, CPOL=0, asynchronous to `clk`.
- `mosi`  in  1  SPI data from the master; sampled on the `sclk` rising edge.
- `ss`  in  1  slave select, active-low.
- `miso`  out  1  SPI data to the master; changes on the `sclk` falling edge; 0 when deselected.
- `o_counter`  out  DATA_W  last accepted payload.
- `o_data_valid`  out  1  one-cycle pulse when `o_counter` updates.
- `o_frame_err`  out  1  one-cycle pulse when a frame is rejected.
- `o_busy`  out  1  high while in SHIFT.

## Operation
- **Input synchronisers.** `sclk`, `mosi` and `ss` each pass through a 2-FF synchroniser.
  - Reset values: `sclk`/`mosi` = 0, `ss` = 1.
  - A third register on `sclk` and `ss` provides edge detection: `sclk_rise`, `sclk_fall`, `ss_fall`, `ss_rise`.
- **State machine: WAIT_IDLE, IDLE, SHIFT, DONE.**
  - WAIT_IDLE (entered on reset): go to IDLE once synced `ss` = 1. Frames already in progress at reset are ignored.
  - IDLE: on `ss_fall`, load `tx_sr` = {HEADER, `o_counter`}, clear `rx_sr` and `bit_cnt`, go to SHIFT.
  - SHIFT:
    - On `sclk_rise`: `rx_sr` <= {`rx_sr`[FRAME_BITS-2:0], `mosi_sync`}. `bit_cnt` increments and saturates at FRAME_BITS+1.
    - On `sclk_fall`: `tx_sr` shifts left, filling with 0.
    - On `ss_rise`: go to DONE. `ss_rise` takes priority over any same-cycle `sclk` edge; that edge is ignored.
  - DONE (one cycle), then IDLE:
    - If `bit_cnt` == FRAME_BITS and `rx_sr`[15:14] == HEADER: `o_counter` <= `rx_sr`[13:0] and pulse `o_data_valid`.
    - Otherwise pulse `o_frame_err`; `o_counter` holds.
- **MISO drive.** `miso` = `tx_sr`[FRAME_BITS-1] when state is SHIFT, else 0.
  - The first bit is valid before the first `sclk` rising edge, as mode 0 requires.
- **Frame length errors.** Short frames (<16 edges) and long frames (>16 edges) are both errors.
  - Extra edges beyond 17 do not wrap `bit_cnt`.
- **Ignored activity.** `sclk` edges while in IDLE or WAIT_IDLE are ignored.
- **Reset values.** `miso` 0, `o_counter` 0, `o_data_valid` 0, `o_frame_err` 0, `o_busy` 0, state WAIT_IDLE.
  - Asserting `reset` mid-frame aborts the frame immediately with no pulse.
- All outputs are registered except `miso`, which is a mux of registered state.

## Timing
- Synchroniser plus edge detect: 3 `clk` cycles from a pin edge to its detected pulse.
- Master constraints:
  - `sclk` high and low phases ≥ 4 `clk` each (max `sclk` = 12.5 MHz).
  - `ss` low to first `sclk` rise ≥ 4 `clk`.
  - Last `sclk` fall to `ss` rise ≥ 4 `clk`.
  - `ss` high time between frames ≥ 4 `clk`.
- MISO bit n+1 appears 4 `clk` after the `sclk` falling pin edge (3 sync + 1 register). The master samples it on the next rising edge.
- `o_data_valid` / `o_frame_err` go high exactly 5 `clk` after the `ss` rising pin edge, for exactly 1 cycle.
  - `o_counter` changes in the same cycle as the `o_data_valid` pulse.
- Back-to-back frames: a new `ss_fall` arriving in DONE is handled in the following IDLE cycle. The edge is held one cycle, so it is not lost.

## Test plan
- **Valid frame.** Reset, then send 16'h9234 (header 10, data 0x1234) at `sclk` = `clk`/8.
  - `o_counter` = 14'h1234 with one `o_data_valid` pulse.
  - MISO returns 16'h8000 (previous counter 0).
- **Echo.** Send 16'h9234, then 16'hBFFF.
  - The second frame's MISO = 16'h9234.
  - `o_counter` = 14'h3FFF after the second frame.
- **Bad header.** Send 16'h5234.
  - `o_frame_err` pulses; `o_counter` holds its prior value; no `o_data_valid`.
- **Length errors.**
  - Deassert `ss` after 15 edges: `o_frame_err` pulses.
  - Send 18 edges: `o_frame_err` pulses, with no wrap to a valid count.
- **Reset mid-frame.** Assert `reset` after 8 bits while `ss` stays low, then finish the frame.
  - No pulses; `o_counter` = 0.
  - The next full frame 16'h8005 is accepted: `o_counter` = 5.
- **Back-to-back frames.** Send frames 16'h8001 to 16'h8064 with 4-`clk` `ss` gaps, using randomised `sclk` phases ≥ 4 `clk`.
  - 100 `o_data_valid` pulses; final `o_counter` = 100.

Source files
------------

// File: rtl/spi_counter_rx.sv
// SPI mode-0 responder: receives {header, counter} frames, presents the payload
// and echoes the last accepted frame on miso. All pins are oversampled in clk.
module spi_counter_rx #(
  parameter int         FRAME_BITS = 16,
  parameter int         DATA_W     = 14,
  parameter logic [1:0] HEADER     = 2'b10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss,
  output logic              miso,
  output logic [DATA_W-1:0] o_counter,
  output logic              o_data_valid,
  output logic              o_frame_err,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_BITS + 1);
  // Bit order of the synchroniser bank: {ss, mosi, sclk}; ss idles high.
  localparam logic [2:0] SYNC_INIT = 3'b100;

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, DONE} state_t;

  logic [2:0] pin_vec;
  logic [2:0] sync_vec;

  assign pin_vec = {ss, mosi, sclk};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      logic meta_b;
      logic sync_b;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          meta_b <= SYNC_INIT[gi];
          sync_b <= SYNC_INIT[gi];
        end else begin
          meta_b <= pin_vec[gi];
          sync_b <= meta_b;
        end
      end
      assign sync_vec[gi] = sync_b;
    end
  endgenerate

  logic sclk_sync, mosi_sync, ss_sync;
  assign sclk_sync = sync_vec[0];
  assign mosi_sync = sync_vec[1];
  assign ss_sync   = sync_vec[2];

  logic sclk_dly_reg, ss_dly_reg;
  logic sclk_rise_reg, sclk_fall_reg, ss_rise_reg, ss_fall_reg;

  // Edge pulses are registered so every pin edge reaches the FSM 3 clk later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_dly_reg  <= 1'b0;
      ss_dly_reg    <= 1'b1;
      sclk_rise_reg <= 1'b0;
      sclk_fall_reg <= 1'b0;
      ss_rise_reg   <= 1'b0;
      ss_fall_reg   <= 1'b0;
    end else begin
      sclk_dly_reg  <= sclk_sync;
      ss_dly_reg    <= ss_sync;
      sclk_rise_reg <= sclk_sync & ~sclk_dly_reg;
      sclk_fall_reg <= ~sclk_sync & sclk_dly_reg;
      ss_rise_reg   <= ss_sync & ~ss_dly_reg;
      ss_fall_reg   <= ~ss_sync & ss_dly_reg;
    end
  end

  state_t                  state_reg, state_next;
  logic [1:0]              settle_reg, settle_next;
  logic [FRAME_BITS-1:0]   tx_sr_reg, tx_sr_next;
  logic [FRAME_BITS-1:0]   rx_sr_reg, rx_sr_next;
  logic [CNT_W-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0]       counter_reg, counter_next;
  logic                    valid_reg, valid_next;
  logic                    err_reg, err_next;
  logic                    busy_reg, busy_next;
  logic                    fall_hold_reg, fall_hold_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= WAIT_IDLE;
      settle_reg    <= 2'd0;
      tx_sr_reg     <= '0;
      rx_sr_reg     <= '0;
      bit_cnt_reg   <= '0;
      counter_reg   <= '0;
      valid_reg     <= 1'b0;
      err_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      fall_hold_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      settle_reg    <= settle_next;
      tx_sr_reg     <= tx_sr_next;
      rx_sr_reg     <= rx_sr_next;
      bit_cnt_reg   <= bit_cnt_next;
      counter_reg   <= counter_next;
      valid_reg     <= valid_next;
      err_reg       <= err_next;
      busy_reg      <= busy_next;
      fall_hold_reg <= fall_hold_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    settle_next    = settle_reg;
    tx_sr_next     = tx_sr_reg;
    rx_sr_next     = rx_sr_reg;
    bit_cnt_next   = bit_cnt_reg;
    counter_next   = counter_reg;
    valid_next     = 1'b0;
    err_next       = 1'b0;
    fall_hold_next = 1'b0;

    case (state_reg)
      WAIT_IDLE: begin
        // Let the synchronisers flush the pin state seen at reset release
        // before trusting ss, so a frame in progress is never picked up.
        if (settle_reg != 2'd3) begin
          settle_next = settle_reg + 2'd1;
        end else if (ss_sync) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (ss_fall_reg || fall_hold_reg) begin
          tx_sr_next   = {HEADER, counter_reg};
          rx_sr_next   = '0;
          bit_cnt_next = '0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_rise_reg) begin
          state_next = DONE;
        end else begin
          if (sclk_rise_reg) begin
            rx_sr_next   = {rx_sr_reg[FRAME_BITS-2:0], mosi_sync};
            bit_cnt_next = (bit_cnt_reg == CNT_MAX) ? bit_cnt_reg : bit_cnt_reg + 1'b1;
          end
          if (sclk_fall_reg) begin
            tx_sr_next = {tx_sr_reg[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      DONE: begin
        state_next     = IDLE;
        fall_hold_next = ss_fall_reg;
        if (bit_cnt_reg == CNT_FRAME && rx_sr_reg[FRAME_BITS-1 -: 2] == HEADER) begin
          counter_next = rx_sr_reg[DATA_W-1:0];
          valid_next   = 1'b1;
        end else begin
          err_next = 1'b1;
        end
      end
      default: state_next = WAIT_IDLE;
    endcase

    busy_next = (state_next == SHIFT);
  end

  assign miso         = (state_reg == SHIFT) ? tx_sr_reg[FRAME_BITS-1] : 1'b0;
  assign o_counter    = counter_reg;
  assign o_data_valid = valid_reg;
  assign o_frame_err  = err_reg;
  assign o_busy       = busy_reg;

endmodule

// File: tb/tb_spi_counter_rx.sv
// Directed bench for spi_counter_rx: a frame-level model predicts each frame's
// outcome, pulse cycle and echo word; a per-cycle process compares the DUT.
module tb_spi_counter_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        ss = 1'b1;
  logic        miso;
  logic [13:0] o_counter;
  logic        o_data_valid;
  logic        o_frame_err;
  logic        o_busy;

  spi_counter_rx dut (
    .clk          (clk),
    .reset        (reset),
    .sclk         (sclk),
    .mosi         (mosi),
    .ss           (ss),
    .miso         (miso),
    .o_counter    (o_counter),
    .o_data_valid (o_data_valid),
    .o_frame_err  (o_frame_err),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          pend_cyc = -1;
  int          pend_kind = 0;  // 0: no pulse, 1: accept, 2: reject
  logic [13:0] pend_data = '0;
  logic [13:0] model_cnt = '0;
  int          valid_seen = 0;
  int          err_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the frame-level model.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (cyc > 2) begin
        if (cyc == pend_cyc) begin
          if (pend_kind == 1) model_cnt = pend_data;
          chk("valid_pulse", o_data_valid, pend_kind == 1);
          chk("err_pulse", o_frame_err, pend_kind == 2);
          chk("busy_after_frame", o_busy, 0);
          pend_cyc = -1;
        end else begin
          chk("valid_quiet", o_data_valid, 0);
          chk("err_quiet", o_frame_err, 0);
        end
        chk("counter", o_counter, model_cnt);
        if (o_data_valid) valid_seen++;
        if (o_frame_err) err_seen++;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL timeout: got no end of test expected finish before time 900000");
    $fatal(1, "timeout");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] word, input int nbits, input bit do_reset,
                            input bit rnd, output logic [15:0] miso_word);
    logic [15:0] expect_echo;
    int lo, hi;
    miso_word = '0;
    @(negedge clk);
    ss = 1'b0;
    wait_clk(5);
    expect_echo = {2'b10, model_cnt};
    for (int i = 0; i < nbits; i++) begin
      lo = rnd ? int'($urandom_range(4, 7)) : 4;
      hi = rnd ? int'($urandom_range(4, 7)) : 4;
      mosi = (i < 16) ? word[15-i] : 1'b0;
      wait_clk(lo);
      sclk = 1'b1;
      if (i < 16) miso_word = {miso_word[14:0], miso};
      if (i == 8 && !do_reset) chk("busy_mid", o_busy, 1);
      wait_clk(hi);
      if (do_reset && i == 7) begin
        reset = 1'b1;
        model_cnt = '0;
        wait_clk(2);
        reset = 1'b0;
      end
      sclk = 1'b0;
    end
    wait_clk(5);
    ss = 1'b1;
    pend_cyc  = cyc + 5;
    pend_data = word[13:0];
    if (do_reset) pend_kind = 0;
    else if (nbits == 16 && word[15:14] == 2'b10) pend_kind = 1;
    else pend_kind = 2;
    if (!do_reset && nbits >= 16) chk("miso_echo", miso_word, expect_echo);
    wait_clk(4);
  endtask

  initial begin
    logic [15:0] w;
    int v0;
    wait_clk(4);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_counter", o_counter, 0);
    chk("reset_miso", miso, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_valid", o_data_valid, 0);
    chk("reset_err", o_frame_err, 0);

    send_frame(16'h9234, 16, 0, 0, w);
    wait_clk(4);
    $display("frame 9234: counter=%h miso=%h", o_counter, w);
    chk("t1_counter", o_counter, 14'h1234);
    chk("t1_miso", w, 16'h8000);
    chk("t1_valid_cnt", valid_seen, 1);

    send_frame(16'hBFFF, 16, 0, 0, w);
    wait_clk(4);
    $display("frame BFFF: counter=%h miso=%h", o_counter, w);
    chk("echo_miso", w, 16'h9234);
    chk("echo_counter", o_counter, 14'h3FFF);

    send_frame(16'h5234, 16, 0, 0, w);
    wait_clk(4);
    $display("frame 5234 (bad header): counter=%h err=%0d", o_counter, err_seen);
    chk("badhdr_counter", o_counter, 14'h3FFF);
    chk("badhdr_err_cnt", err_seen, 1);
    chk("badhdr_valid_cnt", valid_seen, 2);

    send_frame(16'h9234, 15, 0, 0, w);
    wait_clk(4);
    $display("short frame 15 edges: counter=%h err=%0d", o_counter, err_seen);
    chk("short_err_cnt", err_seen, 2);

    send_frame(16'h9234, 18, 0, 0, w);
    wait_clk(4);
    $display("long frame 18 edges: counter=%h err=%0d", o_counter, err_seen);
    chk("long_err_cnt", err_seen, 3);
    chk("long_counter", o_counter, 14'h3FFF);

    send_frame(16'h9234, 16, 1, 0, w);
    wait_clk(4);
    $display("reset mid-frame: counter=%h valid=%0d err=%0d", o_counter, valid_seen, err_seen);
    chk("rst_counter", o_counter, 0);
    chk("rst_err_cnt", err_seen, 3);
    chk("rst_valid_cnt", valid_seen, 2);

    send_frame(16'h8005, 16, 0, 0, w);
    wait_clk(4);
    $display("frame 8005: counter=%h miso=%h", o_counter, w);
    chk("post_rst_counter", o_counter, 14'd5);
    chk("post_rst_miso", w, 16'h8000);

    v0 = valid_seen;
    for (int k = 1; k <= 100; k++) begin
      send_frame(16'h8000 | 16'(k), 16, 0, 1, w);
      $display("b2b frame %0d: word=%h miso=%h", k, 16'h8000 | 16'(k), w);
    end
    wait_clk(8);
    chk("b2b_valid_cnt", valid_seen - v0, 100);
    chk("b2b_counter", o_counter, 14'd100);
    chk("b2b_err_cnt", err_seen, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
